rca_resp_checker: RTL and testbench

- Hardware response checker for the ripple-carry adder; consumes the adder's operand/result pairs and verifies them against a behavioural reference.
- Sits at the output end of the adder datapath. It accepts one vector per valid/ready handshake and counts passes and failures over a fixed-length run.
- It latches the first failing vector for debug, which makes on-board self-test possible without a simulator log file.

---
 rtl/rca_chk_pkg.sv | 22 ++
 rtl/rca_ref_model.sv | 13 +
 rtl/rca_resp_checker.sv | 137 +++++++++++++
 tb/tb_rca_resp_checker.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_chk_pkg.sv
// Shared types and defaults for the ripple-carry adder response checker.
package rca_chk_pkg;

  localparam int unsigned DEF_WIDTH       = 4;
  localparam int unsigned DEF_NUM_VECTORS = 128;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic                 cin;
    logic [DEF_WIDTH-1:0] sum;
    logic                 cout;
  } chk_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } chk_state_t;

endpackage

// File: rtl/rca_ref_model.sv
// Combinational reference adder: full-width {cout,sum} of a + b + cin.
module rca_ref_model #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   expected_c
);

  assign expected_c = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/rca_resp_checker.sv
// Accepts adder operand/result vectors, checks them against a reference adder,
// counts passes/failures over a fixed-length run and latches the first failure.
module rca_resp_checker
  import rca_chk_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned NUM_VECTORS = DEF_NUM_VECTORS,
  parameter int unsigned CNT_W       = $clog2(NUM_VECTORS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_idx,
  output chk_vec_t         first_fail_vec,
  output logic [WIDTH:0]   first_fail_exp
);

  chk_state_t       state, state_nxt;
  logic [CNT_W-1:0] acc_cnt;
  logic             s1_valid;
  chk_vec_t         s1_vec;
  logic [CNT_W-1:0] s1_idx;
  logic [WIDTH:0]   expected_c;
  logic             accept_c;
  logic             last_c;
  logic             start_ok_c;
  logic             match_c;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake decode
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    start_ok_c = 1'b0;
    accept_c   = 1'b0;
    last_c     = 1'b0;
    if (state == RUN && acc_cnt < CNT_W'(NUM_VECTORS)) in_ready = 1'b1;
    accept_c = in_valid && in_ready;
    last_c   = accept_c && (acc_cnt == CNT_W'(NUM_VECTORS - 1));
    case (state)
      IDLE, DONE: begin
        if (start) begin
          start_ok_c = 1'b1;
          state_nxt  = RUN;
        end
      end
      RUN:     if (last_c) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  // Stage 1: capture the accepted vector with its acceptance index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_vec   <= '0;
      s1_idx   <= '0;
    end else if (start_ok_c) begin
      acc_cnt  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_vec.a    <= a;
        s1_vec.b    <= b;
        s1_vec.cin  <= cin;
        s1_vec.sum  <= sum;
        s1_vec.cout <= cout;
        s1_idx      <= acc_cnt;
        acc_cnt     <= acc_cnt + CNT_W'(1);
      end
    end
  end

  rca_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a          (s1_vec.a),
    .b          (s1_vec.b),
    .cin        (s1_vec.cin),
    .expected_c (expected_c)
  );

  assign match_c = ({s1_vec.cout, s1_vec.sum} == expected_c);

  // Stage 2: score the vector; only the first failure of a run is kept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_vec   <= '0;
      first_fail_exp   <= '0;
    end else if (start_ok_c) begin
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_vec   <= '0;
      first_fail_exp   <= '0;
    end else if (s1_valid) begin
      if (match_c) begin
        pass_cnt <= pass_cnt + CNT_W'(1);
      end else begin
        fail_cnt <= fail_cnt + CNT_W'(1);
        if (!first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_idx   <= s1_idx;
          first_fail_vec   <= s1_vec;
          first_fail_exp   <= expected_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_rca_resp_checker.sv
// Self-checking bench for rca_resp_checker: constant vector table, directed
// corner sequences and randomized runs scored by a behavioural model.
module tb_rca_resp_checker;
  import rca_chk_pkg::*;

  localparam int unsigned W  = DEF_WIDTH;
  localparam int unsigned N  = DEF_NUM_VECTORS;
  localparam int unsigned CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_ready;
  logic [W-1:0]  a, b, sum;
  logic          cin, cout;
  logic          busy, done;
  logic [CW-1:0] pass_cnt, fail_cnt, first_fail_idx;
  logic          first_fail_valid;
  chk_vec_t      first_fail_vec;
  logic [W:0]    first_fail_exp;

  always #5 clk = ~clk;

  rca_resp_checker dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .a                (a),
    .b                (b),
    .cin              (cin),
    .sum              (sum),
    .cout             (cout),
    .busy             (busy),
    .done             (done),
    .pass_cnt         (pass_cnt),
    .fail_cnt         (fail_cnt),
    .first_fail_valid (first_fail_valid),
    .first_fail_idx   (first_fail_idx),
    .first_fail_vec   (first_fail_vec),
    .first_fail_exp   (first_fail_exp)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model of one run
  int         m_acc, m_pass, m_fail, m_ffidx;
  bit         m_ffv;
  chk_vec_t   m_ffvec;
  logic [W:0] m_ffexp;
  int         rdy_cycles;

  typedef struct {
    chk_vec_t v;
    bit       match;
  } tv_t;
  tv_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic chk_vec_t mk(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                                  input logic [3:0] vs, input logic vo);
    chk_vec_t v;
    v.a = va; v.b = vb; v.cin = vc; v.sum = vs; v.cout = vo;
    return v;
  endfunction

  function automatic logic [W:0] ref_sum(input chk_vec_t v);
    int s;
    s = int'(v.a) + int'(v.b) + int'(v.cin);
    return (W+1)'(s);
  endfunction

  task automatic model_clear();
    m_acc = 0; m_pass = 0; m_fail = 0; m_ffidx = 0;
    m_ffv = 0; m_ffvec = '0; m_ffexp = '0;
  endtask

  task automatic model_accept(input chk_vec_t v);
    logic [W:0] e;
    e = ref_sum(v);
    if ({v.cout, v.sum} == e) m_pass++;
    else begin
      m_fail++;
      if (!m_ffv) begin
        m_ffv = 1; m_ffidx = m_acc; m_ffvec = v; m_ffexp = e;
      end
    end
    m_acc++;
  endtask

  // mode 0: all correct; 1: directed faults at 5 and 9; 2: random faults
  function automatic chk_vec_t make_vec(input int idx, input int mode);
    chk_vec_t   v;
    logic [W:0] s;
    v.a = W'($urandom); v.b = W'($urandom); v.cin = 1'($urandom); v.sum = '0; v.cout = 1'b0;
    s = ref_sum(v);
    v.sum = s[W-1:0]; v.cout = s[W];
    if (mode == 1 && idx == 5) v = mk(4'hF, 4'h1, 1'b0, 4'h0, 1'b0);
    if (mode == 1 && idx == 9) v = mk(4'h3, 4'h3, 1'b1, 4'h6, 1'b0);
    if (mode == 2 && $urandom_range(7) == 0) v.sum = v.sum ^ W'($urandom_range(15, 1));
    return v;
  endfunction

  task automatic drive(input chk_vec_t v);
    a = v.a; b = v.b; cin = v.cin; sum = v.sum; cout = v.cout;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass_cnt), 0);
    check({tag, "_fail"}, 32'(fail_cnt), 0);
    check({tag, "_ffv"}, 32'(first_fail_valid), 0);
    check({tag, "_ffidx"}, 32'(first_fail_idx), 0);
    check({tag, "_ffvec"}, 32'(first_fail_vec), 0);
    check({tag, "_ffexp"}, 32'(first_fail_exp), 0);
  endtask

  task automatic do_start();
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    model_clear();
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
  endtask

  // Feeds vectors until the model has seen N acceptances (or abort_at is reached)
  task automatic run_vectors(input int mode, input int gap, input int start_at, input int abort_at);
    chk_vec_t v;
    bit adv, st_done;
    int cyc;
    adv = 0; st_done = 0; cyc = 0; rdy_cycles = 0;
    v = make_vec(m_acc, mode);
    while (m_acc < int'(N)) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc > 3000) begin
        check("run_timeout", 32'(m_acc), 32'(N));
        break;
      end
      if (abort_at >= 0 && m_acc == abort_at) begin
        in_valid = 1'b0;
        break;
      end
      if (start_at >= 0 && m_acc == start_at && !st_done) begin
        start = 1'b1; st_done = 1;
      end
      if (adv) begin
        in_valid = 1'b0; adv = 0;
        v = make_vec(m_acc, mode);
      end
      if (!in_valid) in_valid = (gap == 0) || ($urandom_range(99) >= 32'(gap));
      drive(v);
      if (in_ready) rdy_cycles++;
      if (in_valid && in_ready) begin
        model_accept(v);
        adv = 1;
      end
    end
  endtask

  // Called at the negedge just before the final acceptance edge
  task automatic end_checks(input bit hold);
    @(negedge clk);
    start = 1'b0;
    if (!hold) in_valid = 1'b0;
    check("drain_done", 32'(done), 0);
    check("drain_busy", 32'(busy), 1);
    @(negedge clk);
    check("end_done", 32'(done), 1);
    check("end_busy", 32'(busy), 0);
    check("end_in_ready", 32'(in_ready), 0);
    check("end_pass", 32'(pass_cnt), 32'(m_pass));
    check("end_fail", 32'(fail_cnt), 32'(m_fail));
    check("end_ffv", 32'(first_fail_valid), 32'(m_ffv));
    check("end_ffidx", 32'(first_fail_idx), 32'(m_ffidx));
    check("end_ffvec", 32'(first_fail_vec), 32'(m_ffvec));
    check("end_ffexp", 32'(first_fail_exp), 32'(m_ffexp));
  endtask

  initial begin
    int tp, tf;
    tbl[0] = '{v: mk(4'h0, 4'h0, 1'b0, 4'h0, 1'b0), match: 1'b1};
    tbl[1] = '{v: mk(4'hF, 4'hF, 1'b1, 4'hF, 1'b1), match: 1'b1};
    tbl[2] = '{v: mk(4'hF, 4'h1, 1'b0, 4'h0, 1'b1), match: 1'b1};
    tbl[3] = '{v: mk(4'hF, 4'h1, 1'b0, 4'h0, 1'b0), match: 1'b0};
    tbl[4] = '{v: mk(4'h7, 4'h8, 1'b1, 4'h0, 1'b1), match: 1'b1};
    tbl[5] = '{v: mk(4'h8, 4'h8, 1'b0, 4'h0, 1'b0), match: 1'b0};
    tbl[6] = '{v: mk(4'h5, 4'hA, 1'b0, 4'hF, 1'b0), match: 1'b1};
    tbl[7] = '{v: mk(4'h0, 4'h0, 1'b1, 4'h0, 1'b0), match: 1'b0};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    drive('0);
    model_clear();

    // Reset held with random inputs, then idle with stray in_valid
    repeat (3) begin
      @(negedge clk);
      start = 1'($urandom); in_valid = 1'($urandom);
      drive(make_vec(0, 0));
      check("rst_in_ready", 32'(in_ready), 0);
    end
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      drive(make_vec(0, 2));
    end
    check_all_zero("idle");
    in_valid = 1'b0;

    // Clean run, no gaps
    do_start();
    run_vectors(0, 0, -1, -1);
    check("clean_ready_cycles", 32'(rdy_cycles), 32'(N));
    end_checks(0);
    check("clean_pass", 32'(pass_cnt), 128);

    // Directed first-fail capture
    do_start();
    run_vectors(1, 0, -1, -1);
    end_checks(0);
    check("ff_fail", 32'(fail_cnt), 2);
    check("ff_pass", 32'(pass_cnt), 126);
    check("ff_idx", 32'(first_fail_idx), 5);
    check("ff_exp", 32'(first_fail_exp), 32'h10);
    check("ff_vec", 32'(first_fail_vec), 32'(mk(4'hF, 4'h1, 1'b0, 4'h0, 1'b0)));

    // Backpressure with random faults, then a 129th vector held
    do_start();
    run_vectors(2, 40, -1, -1);
    end_checks(1);
    repeat (5) begin
      @(negedge clk);
      check("extra_in_ready", 32'(in_ready), 0);
      check("extra_total", 32'(pass_cnt) + 32'(fail_cnt), 128);
    end
    in_valid = 1'b0;

    // start during RUN is ignored
    do_start();
    run_vectors(0, 0, 30, -1);
    end_checks(0);
    check("restart_pass", 32'(pass_cnt), 128);

    // start from DONE clears results on the next edge
    @(negedge clk);
    start = 1'b1;
    model_clear();
    @(negedge clk);
    start = 1'b0;
    check("redone_done", 32'(done), 0);
    check("redone_busy", 32'(busy), 1);
    check("redone_pass", 32'(pass_cnt), 0);
    check("redone_ffv", 32'(first_fail_valid), 0);

    // Table vectors, one at a time, checking the one-cycle counter latency
    tp = 0; tf = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(tbl[i].v);
      in_valid = 1'b1;
      check("tbl_ready", 32'(in_ready), 1);
      model_accept(tbl[i].v);
      @(negedge clk);
      in_valid = 1'b0;
      check("tbl_lat_pass", 32'(pass_cnt), 32'(tp));
      check("tbl_lat_fail", 32'(fail_cnt), 32'(tf));
      if (tbl[i].match) tp++;
      else tf++;
      @(negedge clk);
      check("tbl_pass", 32'(pass_cnt), 32'(tp));
      check("tbl_fail", 32'(fail_cnt), 32'(tf));
    end
    check("tbl_ffidx", 32'(first_fail_idx), 3);
    check("tbl_ffexp", 32'(first_fail_exp), 32'h10);
    run_vectors(0, 20, -1, -1);
    end_checks(0);
    check("tbl_final_pass", 32'(pass_cnt), 125);
    check("tbl_final_fail", 32'(fail_cnt), 3);

    // Asynchronous reset in the middle of a run
    do_start();
    run_vectors(2, 0, -1, 60);
    #2 reset = 1'b1;
    #1 check_all_zero("abort");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("abort_idle");
    do_start();
    run_vectors(0, 0, -1, -1);
    end_checks(0);
    check("abort_rerun_pass", 32'(pass_cnt), 128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
